pwm_multichannel: RTL

PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_timebase.sv | 75 +++++++
 rtl/pwm_multichannel.sv | 103 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared register map, mode/direction encodings and reset values for the PWM block.
// No logic here; constants and one address helper only.
package pwm_pkg;

   localparam logic [6:0] ADDR_EN_OUT_LO  = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI  = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO  = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI  = 7'h03;
   localparam logic [6:0] ADDR_TOP        = 7'h04;
   localparam logic [6:0] ADDR_PRESCALE   = 7'h05;
   localparam logic [6:0] ADDR_MODE       = 7'h06;
   localparam logic [6:0] ADDR_DUTY_BASE  = 7'h10;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam logic [7:0] RST_TOP      = 8'hFF;
   localparam logic [7:0] RST_DUTY     = 8'h00;
   localparam logic [7:0] RST_PRESCALE = 8'h00;

   function automatic logic [6:0] duty_addr(input int unsigned k);
      return ADDR_DUTY_BASE + 7'(k);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus up (edge) or up/down (center) period counter; flags the period boundary.
// boundary is combinational in the wrapping tick cycle; no backpressure, free-running.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] prescale,
   input  logic [CNT_W-1:0] top,
   input  logic             mode_center,
   input  logic             pre_clr,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt,
   output logic             boundary
);

   logic [CNT_W-1:0] pre_cnt;
   logic             dir;
   logic             tick;
   logic             wrap;

   assign tick = (pre_cnt == prescale);

   // wrap marks the tick whose next count is 0, i.e. the last tick of the period
   always_comb begin
      wrap = 1'b0;
      if (mode_center == MODE_CENTER) begin
         if (dir == DIR_UP) begin
            wrap = (cnt >= top) && (top <= CNT_W'(1));
         end else begin
            wrap = (cnt <= CNT_W'(1));
         end
      end else begin
         wrap = (cnt >= top);
      end
   end

   assign boundary = tick & wrap & ~cnt_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (pre_clr || tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         dir <= DIR_UP;
      end else if (cnt_clr) begin
         cnt <= '0;
         dir <= DIR_UP;
      end else if (tick) begin
         if (wrap) begin
            cnt <= '0;
            dir <= DIR_UP;
         end else if ((mode_center == MODE_CENTER) && (dir == DIR_UP) && (cnt >= top)) begin
            cnt <= top - CNT_W'(1);
            dir <= DIR_DOWN;
         end else if ((mode_center == MODE_CENTER) && (dir == DIR_DOWN)) begin
            cnt <= cnt - CNT_W'(1);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/pwm_multichannel.sv
// Register-programmed multichannel PWM with shadowed duty/TOP loaded at each period boundary.
// out is registered (1 cycle after cnt/enables); period_tick is registered with the load; no backpressure.
module pwm_multichannel
   import pwm_pkg::*;
#(
   parameter int NUM_CH = 16,
   parameter int CNT_W  = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [6:0]        wr_addr,
   input  logic [7:0]        wr_data,
   output logic [NUM_CH-1:0] out,
   output logic              period_tick
);

   logic [NUM_CH-1:0] en_out;
   logic [NUM_CH-1:0] en_pwm;
   logic [CNT_W-1:0]  duty_stg [NUM_CH];
   logic [CNT_W-1:0]  duty_act [NUM_CH];
   logic [CNT_W-1:0]  top_stg;
   logic [CNT_W-1:0]  top_act;
   logic [CNT_W-1:0]  prescale;
   logic              mode;
   logic [CNT_W-1:0]  cnt;
   logic              boundary;
   logic              wr_prescale;
   logic              mode_chg;

   assign wr_prescale = wr_en && (wr_addr == ADDR_PRESCALE);
   assign mode_chg    = wr_en && (wr_addr == ADDR_MODE) && (wr_data[0] != mode);

   pwm_timebase #(.CNT_W(CNT_W)) u_timebase (
      .clk         (clk),
      .rst_n       (rst_n),
      .prescale    (prescale),
      .top         (top_act),
      .mode_center (mode),
      .pre_clr     (wr_prescale | mode_chg),
      .cnt_clr     (mode_chg),
      .cnt         (cnt),
      .boundary    (boundary)
   );

   // Staged values are sampled before a same-cycle write lands, so a boundary write waits a period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_stg     <= RST_TOP;
         top_act     <= RST_TOP;
         prescale    <= RST_PRESCALE;
         mode        <= MODE_EDGE;
         period_tick <= 1'b0;
      end else begin
         period_tick <= boundary;
         if (boundary) begin
            top_act <= top_stg;
         end
         if (wr_en && (wr_addr == ADDR_TOP)) begin
            top_stg <= wr_data;
         end
         if (wr_prescale) begin
            prescale <= wr_data;
         end
         if (wr_en && (wr_addr == ADDR_MODE)) begin
            mode <= wr_data[0];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam int         BYTE_BIT = g % 8;
      localparam logic [6:0] OUT_ADDR = (g < 8) ? ADDR_EN_OUT_LO : ADDR_EN_OUT_HI;
      localparam logic [6:0] PWM_ADDR = (g < 8) ? ADDR_EN_PWM_LO : ADDR_EN_PWM_HI;
      localparam logic [6:0] DTY_ADDR = duty_addr(g);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            en_out[g]   <= 1'b0;
            en_pwm[g]   <= 1'b0;
            duty_stg[g] <= RST_DUTY;
            duty_act[g] <= RST_DUTY;
            out[g]      <= 1'b0;
         end else begin
            if (wr_en && (wr_addr == OUT_ADDR)) begin
               en_out[g] <= wr_data[BYTE_BIT];
            end
            if (wr_en && (wr_addr == PWM_ADDR)) begin
               en_pwm[g] <= wr_data[BYTE_BIT];
            end
            if (wr_en && (wr_addr == DTY_ADDR)) begin
               duty_stg[g] <= wr_data;
            end
            if (boundary) begin
               duty_act[g] <= duty_stg[g];
            end
            out[g] <= en_out[g] & (~en_pwm[g] | (cnt < duty_act[g]));
         end
      end
   end

endmodule
